// File: rtl/byte_concat_pkg.sv
// -----------------------------------------------------------------------------
// byte_concat_pkg
//   Shared widths, types and helpers for the byte-to-word packer.
//   Contents:
//     WORD_W / BYTE_W / BYTES_PER_WORD : geometry of the packed word
//     CLR_CODE_DEFAULT                 : default framing clear byte
//     word_t / byte_t                  : data types
//     byte_concat_shift()              : inserts one byte into a partial word
// -----------------------------------------------------------------------------
package byte_concat_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t CLR_CODE_DEFAULT = 8'h00;

    // MSB-first: older bytes move up, the new byte enters at the bottom, so
    // the first byte of a word ends in the top lane after four inserts.
    // LSB-first: older bytes move down, the new byte enters at the top, so
    // the first byte of a word ends in the bottom lane.
    function automatic word_t byte_concat_shift(input word_t acc,
                                                input byte_t b,
                                                input bit    msb_first);
        word_t res;
        if (msb_first) begin
            res = {acc[WORD_W-BYTE_W-1:0], b};
        end else begin
            res = {b, acc[WORD_W-1:BYTE_W]};
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_concat.sv
// -----------------------------------------------------------------------------
// byte_concat
//   Collects four consecutive valid bytes into a 32-bit word and presents the
//   completed word on a registered output with a one-cycle valid strobe.
//   A valid byte equal to CLR_CODE (when CLR_EN=1) discards the partial word
//   so that the next byte starts a fresh word.
//
//   Parameters:
//     MSB_FIRST : 1 = first byte lands in out[31:24], 0 = in out[7:0]
//     CLR_EN    : 1 = CLR_CODE acts as a framing clear, 0 = ordinary data
//     CLR_CODE  : framing clear byte value
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     in_valid  in   'in' carries a byte this cycle
//     in        in   input data byte
//     out       out  last completed word (holds until the next completion)
//     out_valid out  one-cycle pulse when 'out' has just been updated
//     byte_cnt  out  bytes currently held in the partial word (0-3)
// -----------------------------------------------------------------------------
module byte_concat
    import byte_concat_pkg::*;
#(
    parameter bit    MSB_FIRST = 1'b1,
    parameter bit    CLR_EN    = 1'b1,
    parameter byte_t CLR_CODE  = CLR_CODE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in,
    output logic [WORD_W-1:0] out,
    output logic              out_valid,
    output logic [1:0]        byte_cnt
);

    word_t      acc_reg,       acc_next;
    logic [1:0] cnt_reg,       cnt_next;
    word_t      out_reg,       out_next;
    logic       out_valid_reg, out_valid_next;

    logic  is_clr;
    word_t shifted;

    assign is_clr  = in_valid && CLR_EN && (in == CLR_CODE);
    assign shifted = byte_concat_shift(acc_reg, in, MSB_FIRST);

    always_comb begin
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;

        if (in_valid) begin
            if (is_clr) begin
                // Clear wins even on what would have been the fourth byte;
                // the partial word is dropped and nothing is emitted.
                acc_next = '0;
                cnt_next = 2'd0;
            end else if (cnt_reg == 2'(BYTES_PER_WORD - 1)) begin
                out_next       = shifted;
                out_valid_next = 1'b1;
                acc_next       = '0;
                cnt_next       = 2'd0;
            end else begin
                acc_next = shifted;
                cnt_next = cnt_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            cnt_reg       <= 2'd0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_byte_concat.sv
// -----------------------------------------------------------------------------
// tb_byte_concat
//   Directed bench for byte_concat. Three instances share one input stream:
//     dut_m : MSB_FIRST=1, CLR_EN=1 (default)
//     dut_l : MSB_FIRST=0, CLR_EN=1
//     dut_n : MSB_FIRST=1, CLR_EN=0
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_byte_concat;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in;

    logic [31:0] out_m, out_l, out_n;
    logic        ov_m, ov_l, ov_n;
    logic [1:0]  cnt_m, cnt_l, cnt_n;

    int total_cnt = 0;
    int pass_cnt  = 0;

    byte_concat #(.MSB_FIRST(1'b1), .CLR_EN(1'b1), .CLR_CODE(8'h00)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
        .out(out_m), .out_valid(ov_m), .byte_cnt(cnt_m));

    byte_concat #(.MSB_FIRST(1'b0), .CLR_EN(1'b1), .CLR_CODE(8'h00)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
        .out(out_l), .out_valid(ov_l), .byte_cnt(cnt_l));

    byte_concat #(.MSB_FIRST(1'b1), .CLR_EN(1'b0), .CLR_CODE(8'h00)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
        .out(out_n), .out_valid(ov_n), .byte_cnt(cnt_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] b);
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        $display("t=%0t in_valid=%0b in=%h | m: out=%h ov=%0b cnt=%0d | l: out=%h ov=%0b | n: out=%h ov=%0b cnt=%0d",
                 $time, v, b, out_m, ov_m, cnt_m, out_l, ov_l, out_n, ov_n, cnt_n);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in       = 8'h00;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        in_valid = 1'b0;
        in       = 8'h00;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out",   out_m,        32'h0);
        check("reset_ov",    {31'b0, ov_m}, 32'h0);
        check("reset_cnt",   {30'b0, cnt_m}, 32'h0);
        rst_n = 1'b1;

        // First word: 01 02 aa bb
        step(1'b1, 8'h01);
        check("w1_cnt1", {30'b0, cnt_m}, 32'd1);
        check("w1_ov1",  {31'b0, ov_m},  32'd0);
        step(1'b1, 8'h02);
        check("w1_cnt2", {30'b0, cnt_m}, 32'd2);
        check("w1_ov2",  {31'b0, ov_m},  32'd0);
        step(1'b1, 8'haa);
        check("w1_cnt3", {30'b0, cnt_m}, 32'd3);
        check("w1_ov3",  {31'b0, ov_m},  32'd0);
        step(1'b1, 8'hbb);
        check("w1_cnt0",   {30'b0, cnt_m}, 32'd0);
        check("w1_ov",     {31'b0, ov_m},  32'd1);
        check("w1_out",    out_m, 32'h0102aabb);
        check("w1_out_lsb", out_l, 32'hbbaa0201);
        check("w1_ov_lsb", {31'b0, ov_l},  32'd1);
        check("w1_out_noclr", out_n, 32'h0102aabb);

        // Second word back-to-back: 2f ee cd de
        step(1'b1, 8'h2f);
        check("w2_pulse_end", {31'b0, ov_m}, 32'd0);
        check("w2_out_hold",  out_m, 32'h0102aabb);
        step(1'b1, 8'hee);
        check("w2_ov_b", {31'b0, ov_m}, 32'd0);
        step(1'b1, 8'hcd);
        check("w2_ov_c", {31'b0, ov_m}, 32'd0);
        step(1'b1, 8'hde);
        check("w2_ov",      {31'b0, ov_m}, 32'd1);
        check("w2_out",     out_m, 32'h2feecdde);
        check("w2_out_lsb", out_l, 32'hdecdee2f);

        // Clear: aa f0 00 dc ff 11 22
        step(1'b1, 8'haa);
        step(1'b1, 8'hf0);
        check("clr_cnt_pre", {30'b0, cnt_m}, 32'd2);
        step(1'b1, 8'h00);
        check("clr_cnt",      {30'b0, cnt_m}, 32'd0);
        check("clr_ov",       {31'b0, ov_m},  32'd0);
        check("clr_out_hold", out_m, 32'h2feecdde);
        check("noclr_cnt",    {30'b0, cnt_n}, 32'd3);
        step(1'b1, 8'hdc);
        check("clr_dc_cnt",  {30'b0, cnt_m}, 32'd1);
        check("clr_dc_ov",   {31'b0, ov_m},  32'd0);
        check("noclr_word",  out_n, 32'haaf000dc);
        check("noclr_ov",    {31'b0, ov_n},  32'd1);
        step(1'b1, 8'hff);
        step(1'b1, 8'h11);
        check("clr_ov_pre", {31'b0, ov_m}, 32'd0);
        step(1'b1, 8'h22);
        check("clr_w_ov",  {31'b0, ov_m}, 32'd1);
        check("clr_w_out", out_m, 32'hdcff1122);

        // Clear arriving at byte_cnt==3 takes priority
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        check("clr3_cnt3", {30'b0, cnt_m}, 32'd3);
        step(1'b1, 8'h00);
        check("clr3_cnt", {30'b0, cnt_m}, 32'd0);
        check("clr3_ov",  {31'b0, ov_m},  32'd0);
        check("clr3_out", out_m, 32'hdcff1122);

        // Gaps: idle cycles carry the clear code but must not act on it
        step(1'b1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00);
            check("gap_ov",  {31'b0, ov_m},  32'd0);
            check("gap_cnt", {30'b0, cnt_m}, 32'd1);
        end
        step(1'b1, 8'h02);
        step(1'b0, 8'h00);
        check("gap2_cnt", {30'b0, cnt_m}, 32'd2);
        check("gap2_ov",  {31'b0, ov_m},  32'd0);
        step(1'b1, 8'haa);
        step(1'b1, 8'hbb);
        check("gap_w_ov",  {31'b0, ov_m}, 32'd1);
        check("gap_w_out", out_m, 32'h0102aabb);
        step(1'b0, 8'h00);
        check("gap_w_ov_end", {31'b0, ov_m}, 32'd0);

        // Asynchronous reset mid-word, between clock edges
        do_reset();
        step(1'b1, 8'hee);
        step(1'b1, 8'hcd);
        check("mid_cnt_pre", {30'b0, cnt_m}, 32'd2);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_cnt", {30'b0, cnt_m}, 32'd0);
        check("async_out", out_m, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'hff);
        check("post_cnt_ff", {30'b0, cnt_m}, 32'd1);
        step(1'b1, 8'h00);
        check("post_clr_cnt", {30'b0, cnt_m}, 32'd0);
        check("post_n_cnt",   {30'b0, cnt_n}, 32'd2);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        check("post_m_cnt",  {30'b0, cnt_m}, 32'd2);
        check("post_m_ov",   {31'b0, ov_m},  32'd0);
        check("post_m_out",  out_m, 32'h0);
        check("post_n_ov",   {31'b0, ov_n},  32'd1);
        check("post_n_out",  out_n, 32'hff000102);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
